data_table_upsert: RTL and testbench
====================================

Name: data_table_upsert

Overview:
- Parametrised successor to the hash-table insert engine; sits between the command dispatcher and the shared data RAM, head table and empty-pointer FIFO.
- Executes one per-task operation: UPSERT, ADD_ONLY or UPDATE_ONLY.
- Adds a bounded chain length, optional head-of-chain insertion and old-value return.
- One task in flight; walks the bucket chain, then writes the node and link in a safe order.

Parameters:
- RAM_LATENCY, 2, cycles from rd_en_o to valid rd_* data.
- A_WIDTH, 10, data-table address width.
- BUCKET_WIDTH, 8, head-table address width.
- KEY_WIDTH, 32, key width.
- VALUE_WIDTH, 32, value width.
- MAX_CHAIN_LEN, 8, maximum nodes per chain (>=1); a legal chain never exceeds it.
- HEAD_INSERT, 0, 0 = append new node at tail; 1 = prepend at head.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- task_valid_i / task_ready_o  in/out  1  task handshake
- task_op_i  in  2  0=UPSERT, 1=ADD_ONLY, 2=UPDATE_ONLY, 3=reserved (treated as UPSERT)
- task_key_i  in  KEY_WIDTH  key
- task_value_i  in  VALUE_WIDTH  value
- task_bucket_i  in  BUCKET_WIDTH  bucket
- task_head_ptr_i  in  A_WIDTH  head pointer
- task_head_ptr_val_i  in  1  head pointer valid
- rd_en_o  out  1  data RAM read enable
- rd_addr_o  out  A_WIDTH  data RAM read address
- rd_key_i, rd_value_i, rd_next_ptr_i, rd_next_ptr_val_i  in  KEY_WIDTH / VALUE_WIDTH / A_WIDTH / 1  read data
- wr_en_o  out  1  data RAM write enable
- wr_addr_o  out  A_WIDTH  write address
- wr_key_o, wr_value_o, wr_next_ptr_o, wr_next_ptr_val_o  out  widths as read data  full node write
- empty_addr_i  in  A_WIDTH  free address; must stay stable until acked
- empty_addr_val_i  in  1  free address available
- empty_addr_rd_ack_o  out  1  pops the free address
- head_wr_en_o  out  1  head table write enable
- head_wr_addr_o  out  BUCKET_WIDTH  head table address
- head_wr_ptr_o  out  A_WIDTH  head pointer value
- head_wr_ptr_val_o  out  1  head pointer valid
- result_valid_o / result_ready_i  out/in  1  result handshake
- result_code_o  out  3  result code
- result_key_o  out  KEY_WIDTH  task key
- result_old_value_o  out  VALUE_WIDTH  previous value on key hit, else 0
- result_chain_len_o  out  $clog2(MAX_CHAIN_LEN+1)  nodes read during walk

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is clk_i. All outputs 0 and state IDLE; task_ready_o=1 from the first clock after reset release.
- Reset mid-operation abandons the task: no ack, no writes, no result.
- Result codes: 0 SUCCESS, 1 SUCCESS_SAME_KEY, 2 TABLE_FULL, 3 KEY_NOT_FOUND, 4 KEY_EXISTS, 5 CHAIN_TOO_LONG.
- task_ready_o=1 only in IDLE. Task captured on valid&&ready.
- States: IDLE, RD_REQ, RD_WAIT, WR_VALUE, WR_NEW, WR_LINK, RESULT.
- IDLE -> RD_REQ if head_ptr_val=1, else go to the insert decision.
- RD_REQ: one-cycle rd_en_o at the current address; counter chain_len++ -> RD_WAIT.
- RD_WAIT holds exactly RAM_LATENCY cycles, then evaluates rd_* data:
  - key match: ADD_ONLY -> RESULT(4); otherwise -> WR_VALUE.
  - no match, next_ptr_val=1: if chain_len==MAX_CHAIN_LEN -> RESULT(5), the loop guard; else address=next_ptr -> RD_REQ.
  - no match, tail reached -> insert decision.
- Insert decision:
  - UPDATE_ONLY -> RESULT(3).
  - chain_len==MAX_CHAIN_LEN -> RESULT(5).
  - !empty_addr_val_i -> RESULT(2).
  - otherwise -> WR_NEW.
- Node write ordering: WR_NEW writes the new node at empty_addr_i, then WR_LINK publishes it. A pointer is never published before its target is written.
  - WR_NEW, HEAD_INSERT=0 or empty chain: next_ptr_val=0.
  - WR_NEW, HEAD_INSERT=1 with an existing head: next_ptr=old head, next_ptr_val=1, no walk write-back.
  - WR_LINK, empty chain or HEAD_INSERT=1: head_wr_en_o, 1 cycle, ptr=empty_addr_i, val=1.
  - WR_LINK, otherwise: rewrite the tail node with its latched key/value and next_ptr=empty_addr_i, val=1.
  - empty_addr_rd_ack_o is pulsed for 1 cycle in WR_LINK. Result SUCCESS(0).
- WR_VALUE: rewrite the matched node with the new value, key and next fields unchanged; result_old_value_o = latched old value; code 1.
- Every wr_en_o / head_wr_en_o / ack is exactly one cycle per state visit.
- RESULT: outputs stable while valid && !ready; -> IDLE on handshake. Back-to-back tasks allowed, so IDLE lasts >=1 cycle.
- HEAD_INSERT=1 still walks the full chain, for the duplicate check and chain_len.

Decomposition:
- Shared package hash_table: op enum, extended rescode enum (6 codes, 3 bits), data-node struct parameterised via the module's widths.
- Reuse rd_data_val_helper (RAM_LATENCY delay of rd_en_o) as the sole sub-module.
- FSM, chain counter and latches stay in this module.

Test Plan:
- Empty bucket, UPSERT key=0x11 val=0xA, empty_addr=5 -> WR_NEW addr5 {0x11,0xA,val=0}, then head_wr bucket ptr=5, ack 1 pulse, code 0, chain_len 0.
- Chain 5->7, UPSERT key at 7 val=0xB (old 0xA) -> reads 5,7; write addr7 value 0xB; code 1, old_value 0xA, chain_len 2, no ack.
- Same chain, new key, HEAD_INSERT=0, empty_addr=9 -> node write addr9, then addr7 next_ptr=9; code 0. With HEAD_INSERT=1 -> addr9 next_ptr=5, head ptr=9.
- ADD_ONLY with existing key -> code 4, no writes. UPDATE_ONLY with absent key -> code 3, no writes, no ack.
- MAX_CHAIN_LEN=2, chain of 2, new key -> code 5, no ack. Corrupt looping chain 5->5 -> code 5 after 2 reads.
- empty_addr_val_i=0, new key -> code 2. result_ready_i held low 10 cycles -> result stable. Reset asserted in RD_WAIT -> no writes, task_ready_o=1 after release.

Source files
------------

// File: rtl/data_table_upsert_pkg.sv
// Shared types for the data-table upsert engine: task opcodes, result codes and FSM states.
package data_table_upsert_pkg;

    typedef enum logic [1:0] {
        OP_UPSERT      = 2'd0,
        OP_ADD_ONLY    = 2'd1,
        OP_UPDATE_ONLY = 2'd2,
        OP_RESERVED    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        RES_SUCCESS          = 3'd0,
        RES_SUCCESS_SAME_KEY = 3'd1,
        RES_TABLE_FULL       = 3'd2,
        RES_KEY_NOT_FOUND    = 3'd3,
        RES_KEY_EXISTS       = 3'd4,
        RES_CHAIN_TOO_LONG   = 3'd5
    } rescode_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_REQ   = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_VALUE = 3'd3,
        ST_WR_NEW   = 3'd4,
        ST_WR_LINK  = 3'd5,
        ST_RESULT   = 3'd6
    } state_e;

endpackage

// File: rtl/data_table_upsert_rd_data_val_helper.sv
// Delays the data RAM read enable by RAM_LATENCY cycles to flag valid read data.
module data_table_upsert_rd_data_val_helper #(
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rd_en_i,
    output logic rd_data_val_o
);

    logic [RAM_LATENCY-1:0] pipe_q;
    logic [RAM_LATENCY-1:0] pipe_d;

    always_comb begin
        pipe_d = (pipe_q << 1) | RAM_LATENCY'(rd_en_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign rd_data_val_o = pipe_q[RAM_LATENCY-1];

endmodule

// File: rtl/data_table_upsert.sv
// Single-task hash-table upsert engine: walks a bucket chain, then writes a new node
// before publishing its pointer, or rewrites the matching node's value in place.
module data_table_upsert
    import data_table_upsert_pkg::*;
#(
    parameter int unsigned RAM_LATENCY   = 2,
    parameter int unsigned A_WIDTH       = 10,
    parameter int unsigned BUCKET_WIDTH  = 8,
    parameter int unsigned KEY_WIDTH     = 32,
    parameter int unsigned VALUE_WIDTH   = 32,
    parameter int unsigned MAX_CHAIN_LEN = 8,
    parameter int unsigned HEAD_INSERT   = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 task_valid_i,
    output logic                                 task_ready_o,
    input  logic [1:0]                           task_op_i,
    input  logic [KEY_WIDTH-1:0]                 task_key_i,
    input  logic [VALUE_WIDTH-1:0]               task_value_i,
    input  logic [BUCKET_WIDTH-1:0]              task_bucket_i,
    input  logic [A_WIDTH-1:0]                   task_head_ptr_i,
    input  logic                                 task_head_ptr_val_i,
    output logic                                 rd_en_o,
    output logic [A_WIDTH-1:0]                   rd_addr_o,
    input  logic [KEY_WIDTH-1:0]                 rd_key_i,
    input  logic [VALUE_WIDTH-1:0]               rd_value_i,
    input  logic [A_WIDTH-1:0]                   rd_next_ptr_i,
    input  logic                                 rd_next_ptr_val_i,
    output logic                                 wr_en_o,
    output logic [A_WIDTH-1:0]                   wr_addr_o,
    output logic [KEY_WIDTH-1:0]                 wr_key_o,
    output logic [VALUE_WIDTH-1:0]               wr_value_o,
    output logic [A_WIDTH-1:0]                   wr_next_ptr_o,
    output logic                                 wr_next_ptr_val_o,
    input  logic [A_WIDTH-1:0]                   empty_addr_i,
    input  logic                                 empty_addr_val_i,
    output logic                                 empty_addr_rd_ack_o,
    output logic                                 head_wr_en_o,
    output logic [BUCKET_WIDTH-1:0]              head_wr_addr_o,
    output logic [A_WIDTH-1:0]                   head_wr_ptr_o,
    output logic                                 head_wr_ptr_val_o,
    output logic                                 result_valid_o,
    input  logic                                 result_ready_i,
    output logic [2:0]                           result_code_o,
    output logic [KEY_WIDTH-1:0]                 result_key_o,
    output logic [VALUE_WIDTH-1:0]               result_old_value_o,
    output logic [$clog2(MAX_CHAIN_LEN+1)-1:0]   result_chain_len_o
);

    localparam int unsigned CL_W = $clog2(MAX_CHAIN_LEN + 1);

    typedef struct packed {
        op_e                     op;
        logic [KEY_WIDTH-1:0]    key;
        logic [VALUE_WIDTH-1:0]  value;
        logic [BUCKET_WIDTH-1:0] bucket;
        logic [A_WIDTH-1:0]      head_ptr;
        logic                    head_val;
        logic [A_WIDTH-1:0]      addr;
        logic [CL_W-1:0]         chain_len;
        logic [KEY_WIDTH-1:0]    tail_key;
        logic [VALUE_WIDTH-1:0]  tail_value;
        logic [VALUE_WIDTH-1:0]  old_value;
    } ctx_t;

    typedef struct packed {
        logic                    task_ready;
        logic                    rd_en;
        logic [A_WIDTH-1:0]      rd_addr;
        logic                    wr_en;
        logic [A_WIDTH-1:0]      wr_addr;
        logic [KEY_WIDTH-1:0]    wr_key;
        logic [VALUE_WIDTH-1:0]  wr_value;
        logic [A_WIDTH-1:0]      wr_next_ptr;
        logic                    wr_next_ptr_val;
        logic                    ack;
        logic                    head_wr_en;
        logic [BUCKET_WIDTH-1:0] head_wr_addr;
        logic [A_WIDTH-1:0]      head_wr_ptr;
        logic                    head_wr_ptr_val;
        logic                    result_valid;
        rescode_e                result_code;
        logic [KEY_WIDTH-1:0]    result_key;
        logic [VALUE_WIDTH-1:0]  result_old_value;
        logic [CL_W-1:0]         result_chain_len;
    } out_t;

    state_e   state_q, state_d;
    ctx_t     ctx_q, ctx_d;
    out_t     out_q, out_d;
    logic     rd_data_val;
    logic     ins_go;
    logic     res_go;
    rescode_e res_code;

    data_table_upsert_rd_data_val_helper #(
        .RAM_LATENCY (RAM_LATENCY)
    ) u_rd_data_val_helper (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rd_en_i       (out_q.rd_en),
        .rd_data_val_o (rd_data_val)
    );

    always_comb begin
        state_d             = state_q;
        ctx_d               = ctx_q;
        out_d               = out_q;
        out_d.rd_en         = 1'b0;
        out_d.wr_en         = 1'b0;
        out_d.ack           = 1'b0;
        out_d.head_wr_en    = 1'b0;
        ins_go              = 1'b0;
        res_go              = 1'b0;
        res_code            = RES_SUCCESS;

        case (state_q)
            ST_IDLE: begin
                if (task_valid_i && out_q.task_ready) begin
                    ctx_d.op        = op_e'(task_op_i);
                    ctx_d.key       = task_key_i;
                    ctx_d.value     = task_value_i;
                    ctx_d.bucket    = task_bucket_i;
                    ctx_d.head_ptr  = task_head_ptr_i;
                    ctx_d.head_val  = task_head_ptr_val_i;
                    ctx_d.addr      = task_head_ptr_i;
                    ctx_d.chain_len = '0;
                    ctx_d.old_value = '0;
                    if (task_head_ptr_val_i) begin
                        state_d       = ST_RD_REQ;
                        out_d.rd_en   = 1'b1;
                        out_d.rd_addr = task_head_ptr_i;
                    end else begin
                        ins_go = 1'b1;
                    end
                end
            end
            ST_RD_REQ: begin
                ctx_d.chain_len = ctx_q.chain_len + CL_W'(1);
                state_d         = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (rd_data_val) begin
                    if (rd_key_i == ctx_q.key) begin
                        ctx_d.old_value = rd_value_i;
                        if (ctx_q.op == OP_ADD_ONLY) begin
                            res_go   = 1'b1;
                            res_code = RES_KEY_EXISTS;
                        end else begin
                            state_d               = ST_WR_VALUE;
                            out_d.wr_en           = 1'b1;
                            out_d.wr_addr         = ctx_q.addr;
                            out_d.wr_key          = rd_key_i;
                            out_d.wr_value        = ctx_q.value;
                            out_d.wr_next_ptr     = rd_next_ptr_i;
                            out_d.wr_next_ptr_val = rd_next_ptr_val_i;
                        end
                    end else if (rd_next_ptr_val_i) begin
                        // Loop guard: a legal chain never has a successor after MAX_CHAIN_LEN nodes.
                        if (ctx_q.chain_len == CL_W'(MAX_CHAIN_LEN)) begin
                            res_go   = 1'b1;
                            res_code = RES_CHAIN_TOO_LONG;
                        end else begin
                            ctx_d.addr    = rd_next_ptr_i;
                            state_d       = ST_RD_REQ;
                            out_d.rd_en   = 1'b1;
                            out_d.rd_addr = rd_next_ptr_i;
                        end
                    end else begin
                        ctx_d.tail_key   = rd_key_i;
                        ctx_d.tail_value = rd_value_i;
                        ins_go           = 1'b1;
                    end
                end
            end
            ST_WR_VALUE: begin
                res_go   = 1'b1;
                res_code = RES_SUCCESS_SAME_KEY;
            end
            ST_WR_NEW: begin
                state_d   = ST_WR_LINK;
                out_d.ack = 1'b1;
                if (!ctx_q.head_val || (HEAD_INSERT != 0)) begin
                    out_d.head_wr_en      = 1'b1;
                    out_d.head_wr_addr    = ctx_q.bucket;
                    out_d.head_wr_ptr     = empty_addr_i;
                    out_d.head_wr_ptr_val = 1'b1;
                end else begin
                    out_d.wr_en           = 1'b1;
                    out_d.wr_addr         = ctx_q.addr;
                    out_d.wr_key          = ctx_q.tail_key;
                    out_d.wr_value        = ctx_q.tail_value;
                    out_d.wr_next_ptr     = empty_addr_i;
                    out_d.wr_next_ptr_val = 1'b1;
                end
            end
            ST_WR_LINK: begin
                res_go   = 1'b1;
                res_code = RES_SUCCESS;
            end
            ST_RESULT: begin
                if (result_ready_i) begin
                    state_d                = ST_IDLE;
                    out_d.result_valid     = 1'b0;
                    out_d.result_code      = RES_SUCCESS;
                    out_d.result_key       = '0;
                    out_d.result_old_value = '0;
                    out_d.result_chain_len = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Insert decision: the new node is written first, its pointer published in WR_LINK.
        if (ins_go) begin
            if (ctx_d.op == OP_UPDATE_ONLY) begin
                res_go   = 1'b1;
                res_code = RES_KEY_NOT_FOUND;
            end else if (ctx_d.chain_len == CL_W'(MAX_CHAIN_LEN)) begin
                res_go   = 1'b1;
                res_code = RES_CHAIN_TOO_LONG;
            end else if (!empty_addr_val_i) begin
                res_go   = 1'b1;
                res_code = RES_TABLE_FULL;
            end else begin
                state_d               = ST_WR_NEW;
                out_d.wr_en           = 1'b1;
                out_d.wr_addr         = empty_addr_i;
                out_d.wr_key          = ctx_d.key;
                out_d.wr_value        = ctx_d.value;
                out_d.wr_next_ptr     = '0;
                out_d.wr_next_ptr_val = 1'b0;
                if ((HEAD_INSERT != 0) && ctx_d.head_val) begin
                    out_d.wr_next_ptr     = ctx_d.head_ptr;
                    out_d.wr_next_ptr_val = 1'b1;
                end
            end
        end

        if (res_go) begin
            state_d                = ST_RESULT;
            out_d.result_valid     = 1'b1;
            out_d.result_code      = res_code;
            out_d.result_key       = ctx_d.key;
            out_d.result_old_value = ctx_d.old_value;
            out_d.result_chain_len = ctx_d.chain_len;
        end

        out_d.task_ready = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ctx_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            out_q   <= out_d;
        end
    end

    assign task_ready_o        = out_q.task_ready;
    assign rd_en_o             = out_q.rd_en;
    assign rd_addr_o           = out_q.rd_addr;
    assign wr_en_o             = out_q.wr_en;
    assign wr_addr_o           = out_q.wr_addr;
    assign wr_key_o            = out_q.wr_key;
    assign wr_value_o          = out_q.wr_value;
    assign wr_next_ptr_o       = out_q.wr_next_ptr;
    assign wr_next_ptr_val_o   = out_q.wr_next_ptr_val;
    assign empty_addr_rd_ack_o = out_q.ack;
    assign head_wr_en_o        = out_q.head_wr_en;
    assign head_wr_addr_o      = out_q.head_wr_addr;
    assign head_wr_ptr_o       = out_q.head_wr_ptr;
    assign head_wr_ptr_val_o   = out_q.head_wr_ptr_val;
    assign result_valid_o      = out_q.result_valid;
    assign result_code_o       = out_q.result_code;
    assign result_key_o        = out_q.result_key;
    assign result_old_value_o  = out_q.result_old_value;
    assign result_chain_len_o  = out_q.result_chain_len;

endmodule

// File: tb/tb_data_table_upsert.sv
// Directed bench: instance 0 appends at tail (chain limit 8), instance 1 prepends (chain limit 2).
module tb_data_table_upsert;

    logic        clk;
    logic        rst;
    logic        tv      [2];
    logic        tready  [2];
    logic [1:0]  t_op;
    logic [31:0] t_key;
    logic [31:0] t_val;
    logic [7:0]  t_bucket;
    logic [9:0]  t_hptr;
    logic        t_hval;
    logic        rd_en   [2];
    logic [9:0]  rd_addr [2];
    logic [31:0] rd_key;
    logic [31:0] rd_value;
    logic [9:0]  rd_nptr;
    logic        rd_nval;
    logic        wr_en   [2];
    logic [9:0]  wr_addr [2];
    logic [31:0] wr_key  [2];
    logic [31:0] wr_value[2];
    logic [9:0]  wr_nptr [2];
    logic        wr_nval [2];
    logic [9:0]  empty_addr;
    logic        empty_val;
    logic        ack     [2];
    logic        hwe     [2];
    logic [7:0]  hwa     [2];
    logic [9:0]  hwp     [2];
    logic        hwv     [2];
    logic        rv      [2];
    logic        rready;
    logic [2:0]  rcode   [2];
    logic [31:0] rkey    [2];
    logic [31:0] rold    [2];
    logic [3:0]  rlen0;
    logic [1:0]  rlen1;

    // Data RAM model
    logic [31:0] mem_key  [1024];
    logic [31:0] mem_val  [1024];
    logic [9:0]  mem_nptr [1024];
    logic        mem_nval [1024];
    logic [9:0]  rp1, rp2;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_cnt, wr_cnt, hw_cnt, ack_cnt, wr_cyc0, hw_cyc;
    logic [9:0]  rd_log  [4];
    logic [9:0]  wl_addr [4];
    logic [31:0] wl_key  [4];
    logic [31:0] wl_val  [4];
    logic [9:0]  wl_nptr [4];
    logic        wl_nval [4];
    logic [7:0]  hw_addr;
    logic [9:0]  hw_ptr;
    logic        hw_val;
    logic [2:0]  res_code;
    logic [31:0] res_key;
    logic [31:0] res_old;
    int          res_len;
    int          drops;

    data_table_upsert #(.MAX_CHAIN_LEN(8), .HEAD_INSERT(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .task_valid_i(tv[0]), .task_ready_o(tready[0]), .task_op_i(t_op),
        .task_key_i(t_key), .task_value_i(t_val), .task_bucket_i(t_bucket),
        .task_head_ptr_i(t_hptr), .task_head_ptr_val_i(t_hval),
        .rd_en_o(rd_en[0]), .rd_addr_o(rd_addr[0]),
        .rd_key_i(rd_key), .rd_value_i(rd_value), .rd_next_ptr_i(rd_nptr), .rd_next_ptr_val_i(rd_nval),
        .wr_en_o(wr_en[0]), .wr_addr_o(wr_addr[0]), .wr_key_o(wr_key[0]), .wr_value_o(wr_value[0]),
        .wr_next_ptr_o(wr_nptr[0]), .wr_next_ptr_val_o(wr_nval[0]),
        .empty_addr_i(empty_addr), .empty_addr_val_i(empty_val), .empty_addr_rd_ack_o(ack[0]),
        .head_wr_en_o(hwe[0]), .head_wr_addr_o(hwa[0]), .head_wr_ptr_o(hwp[0]), .head_wr_ptr_val_o(hwv[0]),
        .result_valid_o(rv[0]), .result_ready_i(rready), .result_code_o(rcode[0]),
        .result_key_o(rkey[0]), .result_old_value_o(rold[0]), .result_chain_len_o(rlen0)
    );

    data_table_upsert #(.MAX_CHAIN_LEN(2), .HEAD_INSERT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .task_valid_i(tv[1]), .task_ready_o(tready[1]), .task_op_i(t_op),
        .task_key_i(t_key), .task_value_i(t_val), .task_bucket_i(t_bucket),
        .task_head_ptr_i(t_hptr), .task_head_ptr_val_i(t_hval),
        .rd_en_o(rd_en[1]), .rd_addr_o(rd_addr[1]),
        .rd_key_i(rd_key), .rd_value_i(rd_value), .rd_next_ptr_i(rd_nptr), .rd_next_ptr_val_i(rd_nval),
        .wr_en_o(wr_en[1]), .wr_addr_o(wr_addr[1]), .wr_key_o(wr_key[1]), .wr_value_o(wr_value[1]),
        .wr_next_ptr_o(wr_nptr[1]), .wr_next_ptr_val_o(wr_nval[1]),
        .empty_addr_i(empty_addr), .empty_addr_val_i(empty_val), .empty_addr_rd_ack_o(ack[1]),
        .head_wr_en_o(hwe[1]), .head_wr_addr_o(hwa[1]), .head_wr_ptr_o(hwp[1]), .head_wr_ptr_val_o(hwv[1]),
        .result_valid_o(rv[1]), .result_ready_i(rready), .result_code_o(rcode[1]),
        .result_key_o(rkey[1]), .result_old_value_o(rold[1]), .result_chain_len_o(rlen1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle read latency shared by both instances (only one is ever active).
    always @(posedge clk) begin
        rp1 <= rd_en[1] ? rd_addr[1] : rd_addr[0];
        rp2 <= rp1;
    end
    assign rd_key   = mem_key[rp2];
    assign rd_value = mem_val[rp2];
    assign rd_nptr  = mem_nptr[rp2];
    assign rd_nval  = mem_nval[rp2];

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) begin
                if (rd_cnt < 4) rd_log[rd_cnt] = rd_addr[i];
                rd_cnt = rd_cnt + 1;
            end
            if (wr_en[i]) begin
                if (wr_cnt < 4) begin
                    wl_addr[wr_cnt] = wr_addr[i];
                    wl_key[wr_cnt]  = wr_key[i];
                    wl_val[wr_cnt]  = wr_value[i];
                    wl_nptr[wr_cnt] = wr_nptr[i];
                    wl_nval[wr_cnt] = wr_nval[i];
                end
                if (wr_cnt == 0) wr_cyc0 = cyc;
                wr_cnt = wr_cnt + 1;
                mem_key[wr_addr[i]]  = wr_key[i];
                mem_val[wr_addr[i]]  = wr_value[i];
                mem_nptr[wr_addr[i]] = wr_nptr[i];
                mem_nval[wr_addr[i]] = wr_nval[i];
            end
            if (hwe[i]) begin
                hw_cnt  = hw_cnt + 1;
                hw_addr = hwa[i];
                hw_ptr  = hwp[i];
                hw_val  = hwv[i];
                hw_cyc  = cyc;
            end
            if (ack[i]) ack_cnt = ack_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic node(input int a, input logic [31:0] k, input logic [31:0] v,
                        input logic [9:0] np, input logic nv);
        mem_key[a] = k; mem_val[a] = v; mem_nptr[a] = np; mem_nval[a] = nv;
    endtask

    task automatic run(input int sel, input logic [1:0] op, input logic [31:0] key,
                       input logic [31:0] val, input logic [7:0] bucket,
                       input logic [9:0] hptr, input logic hval, input int hold);
        int n;
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0; hw_cnt = 0; ack_cnt = 0; wr_cyc0 = 0; hw_cyc = 0; drops = 0;
        t_op = op; t_key = key; t_val = val; t_bucket = bucket; t_hptr = hptr; t_hval = hval;
        n = 0;
        while (!tready[sel] && n < 20) begin @(negedge clk); n++; end
        chk("task_ready_wait", 64'(tready[sel]), 64'd1);
        tv[sel] = 1'b1;
        @(negedge clk);
        tv[sel] = 1'b0;
        n = 0;
        while (!rv[sel] && n < 200) begin @(negedge clk); n++; end
        chk("result_valid_wait", 64'(rv[sel]), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rv[sel]) drops++;
        end
        res_code = rcode[sel];
        res_key  = rkey[sel];
        res_old  = rold[sel];
        res_len  = (sel == 0) ? int'(rlen0) : int'(rlen1);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) node(i, 32'h0, 32'h0, 10'h0, 1'b0);
        rst = 1'b1; rready = 1'b0; tv[0] = 1'b0; tv[1] = 1'b0;
        t_op = 2'd0; t_key = '0; t_val = '0; t_bucket = '0; t_hptr = '0; t_hval = 1'b0;
        empty_addr = 10'd0; empty_val = 1'b0;
        rd_cnt = 0; wr_cnt = 0; hw_cnt = 0; ack_cnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(tready[0]), 64'd0);
        chk("rst_result_valid", 64'(rv[0]), 64'd0);
        chk("rst_wr_en", 64'(wr_en[0]), 64'd0);
        chk("rst_head_wr_en", 64'(hwe[1]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst0", 64'(tready[0]), 64'd1);
        chk("ready_after_rst1", 64'(tready[1]), 64'd1);

        // Empty bucket insert
        empty_addr = 10'd5; empty_val = 1'b1;
        run(0, 2'd0, 32'h11, 32'hA, 8'd3, 10'd0, 1'b0, 0);
        chk("t1_code", 64'(res_code), 64'd0);
        chk("t1_len", 64'(res_len), 64'd0);
        chk("t1_key", 64'(res_key), 64'h11);
        chk("t1_old", 64'(res_old), 64'd0);
        chk("t1_reads", 64'(rd_cnt), 64'd0);
        chk("t1_wr_cnt", 64'(wr_cnt), 64'd1);
        chk("t1_wr_node", {22'h0, wl_addr[0], wl_key[0]}, {22'h0, 10'd5, 32'h11});
        chk("t1_wr_val", {31'h0, wl_nval[0], wl_val[0]}, {31'h0, 1'b0, 32'hA});
        chk("t1_head_wr", {43'h0, hw_cnt[0], hw_addr, hw_ptr, hw_val}, {43'h0, 1'b1, 8'd3, 10'd5, 1'b1});
        chk("t1_head_cnt", 64'(hw_cnt), 64'd1);
        chk("t1_order", 64'(hw_cyc), 64'(wr_cyc0 + 1));
        chk("t1_ack", 64'(ack_cnt), 64'd1);

        // Build chain 5->7
        node(5, 32'h11, 32'hA, 10'd7, 1'b1);
        node(7, 32'h22, 32'hA, 10'd0, 1'b0);

        // Key hit at tail: value rewrite
        run(0, 2'd0, 32'h22, 32'hB, 8'd3, 10'd5, 1'b1, 0);
        chk("t2_code", 64'(res_code), 64'd1);
        chk("t2_old", 64'(res_old), 64'hA);
        chk("t2_len", 64'(res_len), 64'd2);
        chk("t2_reads", 64'(rd_cnt), 64'd2);
        chk("t2_rd_addrs", {44'h0, rd_log[0], rd_log[1]}, {44'h0, 10'd5, 10'd7});
        chk("t2_wr", {21'h0, wr_cnt[0], wl_addr[0], wl_val[0]}, {21'h0, 1'b1, 10'd7, 32'hB});
        chk("t2_wr_fields", {21'h0, wl_nval[0], wl_nptr[0], wl_key[0]}, {21'h0, 1'b0, 10'd0, 32'h22});
        chk("t2_ack", 64'(ack_cnt), 64'd0);
        chk("t2_head", 64'(hw_cnt), 64'd0);

        // New key appended at tail
        empty_addr = 10'd9;
        run(0, 2'd0, 32'h33, 32'hC, 8'd3, 10'd5, 1'b1, 0);
        chk("t3_code", 64'(res_code), 64'd0);
        chk("t3_len", 64'(res_len), 64'd2);
        chk("t3_wr_cnt", 64'(wr_cnt), 64'd2);
        chk("t3_new", {12'h0, wl_addr[0], wl_key[0], wl_nval[0], wl_val[0][8:0]}, {12'h0, 10'd9, 32'h33, 1'b0, 9'hC});
        chk("t3_link", {11'h0, wl_addr[1], wl_key[1], wl_nval[1], wl_nptr[1]}, {11'h0, 10'd7, 32'h22, 1'b1, 10'd9});
        chk("t3_link_val", 64'(wl_val[1]), 64'hB);
        chk("t3_ack", 64'(ack_cnt), 64'd1);
        chk("t3_head", 64'(hw_cnt), 64'd0);

        // ADD_ONLY on existing key
        empty_addr = 10'd11;
        run(0, 2'd1, 32'h22, 32'hE, 8'd3, 10'd5, 1'b1, 0);
        chk("t4_code", 64'(res_code), 64'd4);
        chk("t4_old", 64'(res_old), 64'hB);
        chk("t4_writes", 64'(wr_cnt + hw_cnt + ack_cnt), 64'd0);

        // UPDATE_ONLY on absent key walks 5->7->9
        run(0, 2'd2, 32'h44, 32'hE, 8'd3, 10'd5, 1'b1, 0);
        chk("t5_code", 64'(res_code), 64'd3);
        chk("t5_len", 64'(res_len), 64'd3);
        chk("t5_old", 64'(res_old), 64'd0);
        chk("t5_writes", 64'(wr_cnt + hw_cnt + ack_cnt), 64'd0);

        // No free address
        empty_val = 1'b0;
        run(0, 2'd0, 32'h55, 32'hE, 8'd3, 10'd5, 1'b1, 0);
        chk("t6_code", 64'(res_code), 64'd2);
        chk("t6_writes", 64'(wr_cnt + hw_cnt + ack_cnt), 64'd0);
        empty_val = 1'b1;

        // Result held under backpressure
        run(0, 2'd1, 32'h33, 32'hE, 8'd3, 10'd5, 1'b1, 10);
        chk("t7_valid_drops", 64'(drops), 64'd0);
        chk("t7_code", 64'(res_code), 64'd4);
        chk("t7_old", 64'(res_old), 64'hC);
        chk("t7_key", 64'(res_key), 64'h33);

        // Reserved op behaves as UPSERT
        run(0, 2'd3, 32'h33, 32'hD, 8'd3, 10'd5, 1'b1, 0);
        chk("t8_code", 64'(res_code), 64'd1);
        chk("t8_len", 64'(res_len), 64'd3);
        chk("t8_wr", {22'h0, wl_addr[0], wl_val[0]}, {22'h0, 10'd9, 32'hD});

        // Instance 1: full chain of 2, new key
        node(20, 32'h66, 32'h1, 10'd21, 1'b1);
        node(21, 32'h77, 32'h2, 10'd0, 1'b0);
        empty_addr = 10'd12;
        run(1, 2'd0, 32'h88, 32'h5, 8'd4, 10'd20, 1'b1, 0);
        chk("t9_code", 64'(res_code), 64'd5);
        chk("t9_len", 64'(res_len), 64'd2);
        chk("t9_writes", 64'(wr_cnt + hw_cnt + ack_cnt), 64'd0);

        // Instance 1: head insert in front of a single node
        node(30, 32'h99, 32'h3, 10'd0, 1'b0);
        run(1, 2'd0, 32'hAA, 32'h4, 8'd4, 10'd30, 1'b1, 0);
        chk("t10_code", 64'(res_code), 64'd0);
        chk("t10_len", 64'(res_len), 64'd1);
        chk("t10_wr_cnt", 64'(wr_cnt), 64'd1);
        chk("t10_new", {11'h0, wl_addr[0], wl_key[0], wl_nval[0], wl_nptr[0]}, {11'h0, 10'd12, 32'hAA, 1'b1, 10'd30});
        chk("t10_head", {44'h0, hw_addr, hw_ptr, hw_val, hw_cnt[0]}, {44'h0, 8'd4, 10'd12, 1'b1, 1'b1});
        chk("t10_ack", 64'(ack_cnt), 64'd1);

        // Instance 1: self-looping corrupt chain
        node(40, 32'h01, 32'h0, 10'd40, 1'b1);
        run(1, 2'd0, 32'hBB, 32'h6, 8'd4, 10'd40, 1'b1, 0);
        chk("t11_code", 64'(res_code), 64'd5);
        chk("t11_reads", 64'(rd_cnt), 64'd2);
        chk("t11_writes", 64'(wr_cnt + hw_cnt + ack_cnt), 64'd0);

        // Reset while waiting on read data
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0; hw_cnt = 0; ack_cnt = 0;
        t_op = 2'd0; t_key = 32'h22; t_val = 32'hF; t_bucket = 8'd3; t_hptr = 10'd5; t_hval = 1'b1;
        chk("t12_ready", 64'(tready[0]), 64'd1);
        tv[0] = 1'b1;
        @(negedge clk);
        tv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t12_ready_in_rst", 64'(tready[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t12_ready_after", 64'(tready[0]), 64'd1);
        repeat (6) @(negedge clk);
        chk("t12_reads", 64'(rd_cnt), 64'd1);
        chk("t12_writes", 64'(wr_cnt + hw_cnt + ack_cnt), 64'd0);
        chk("t12_no_result", 64'(rv[0]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
